// File: rtl/arbitro_salida.sv
// arbitro_salida: 4:1 work-conserving round-robin merge of the channel FIFOs into the output FIFO.
// Optional weighted bursts (W0..W3 consecutive grants per channel) with `define ARBITRO_SALIDA_WRR_EN.
module arbitro_salida #(
  parameter int DATA_WIDTH = 6,
  parameter int W0         = 4,
  parameter int W1         = 2,
  parameter int W2         = 1,
  parameter int W3         = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            state,
  input  logic                  empty0,
  input  logic                  empty1,
  input  logic                  empty2,
  input  logic                  empty3,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  input  logic                  almost_full_out,
  output logic                  pop0,
  output logic                  pop1,
  output logic                  pop2,
  output logic                  pop3,
  output logic                  push_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            grant,
  output logic                  idle
);
  localparam logic [3:0] ST_RESET = 4'b0001;

  logic                  flush;
  logic                  go;
  logic [3:0]            empty_vec;
  logic [3:0]            pop_vec;
  logic [1:0]            ptr;
  logic [1:0]            ptr_next;
  logic [1:0]            sel;
  logic [DATA_WIDTH-1:0] mux_data;
  logic [DATA_WIDTH-1:0] hold_data;

  function automatic logic [2:0] weight(input logic [1:0] ch);
    case (ch)
      2'd0:    weight = 3'(W0);
      2'd1:    weight = 3'(W1);
      2'd2:    weight = 3'(W2);
      default: weight = 3'(W3);
    endcase
  endfunction

  assign flush     = reset | (state == ST_RESET);
  assign empty_vec = {empty3, empty2, empty1, empty0};
  assign go        = !flush & !almost_full_out & !(&empty_vec);

  // First non-empty channel searching upward from ptr
  always_comb begin
    logic [1:0] idx;
    logic       found;
    sel   = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && !empty_vec[idx]) begin
        sel   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // One-hot read strobe for the selected channel
  always_comb begin
    if (go) begin
      pop_vec = 4'b0001 << sel;
    end else begin
      pop_vec = 4'b0000;
    end
  end

  assign {pop3, pop2, pop1, pop0} = pop_vec;

  // Channel data is valid the cycle after its pop, so steer by the registered grant
  always_comb begin
    case (grant)
      2'd0:    mux_data = data_in0;
      2'd1:    mux_data = data_in1;
      2'd2:    mux_data = data_in2;
      default: mux_data = data_in3;
    endcase
  end

`ifdef ARBITRO_SALIDA_WRR_EN
  logic [2:0] cnt;
  logic [2:0] cnt_next;
  logic [2:0] burst_n;

  if (W0 < 1 || W0 > 7 || W1 < 1 || W1 > 7 || W2 < 1 || W2 > 7 || W3 < 1 || W3 > 7) begin : g_bad_weight
    $error("arbitro_salida: W0..W3 must lie in 1..7");
  end

  // Stay on the granted channel until it has used its burst weight
  always_comb begin
    burst_n = ((sel == ptr) ? cnt : 3'd0) + 3'd1;
    if (!go) begin
      ptr_next = ptr;
      cnt_next = cnt;
    end else if (burst_n < weight(sel)) begin
      ptr_next = sel;
      cnt_next = burst_n;
    end else begin
      ptr_next = sel + 2'd1;
      cnt_next = 3'd0;
    end
  end

  // Burst counter register
  always_ff @(posedge clk) begin
    if (flush) begin
      cnt <= 3'd0;
    end else begin
      cnt <= cnt_next;
    end
  end
`else
  // Plain round-robin: move past the granted channel
  always_comb begin
    if (go) begin
      ptr_next = sel + 2'd1;
    end else begin
      ptr_next = ptr;
    end
  end
`endif

  // Output strobe, grant, pointer and held data registers
  always_ff @(posedge clk) begin
    if (flush) begin
      push_out  <= 1'b0;
      grant     <= 2'd0;
      ptr       <= 2'd0;
      hold_data <= {DATA_WIDTH{1'b0}};
    end else begin
      push_out  <= go;
      grant     <= go ? sel : grant;
      ptr       <= ptr_next;
      hold_data <= push_out ? mux_data : hold_data;
    end
  end

  assign data_out = push_out ? mux_data : hold_data;
  assign idle     = (&empty_vec) & !push_out;

endmodule

// File: tb/tb_arbitro_salida.sv
// Self-checking bench for arbitro_salida: channel FIFO model plus a push scoreboard.
// Grant order per scenario is compared against fixed expected sequences.
module tb_arbitro_salida;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    state = 4'b0010;
  logic          almost_full_out = 1'b0;
  logic          empty0, empty1, empty2, empty3;
  logic [DW-1:0] din [4];
  logic          pop0, pop1, pop2, pop3;
  logic          push_out;
  logic [DW-1:0] data_out;
  logic [1:0]    grant;
  logic          idle;

  int            pushed [4] = '{0, 0, 0, 0};
  int            popped [4] = '{0, 0, 0, 0};
  logic [DW-1:0] mem [4][256];
  logic [7:0]    exp_q [$];
  logic [7:0]    exp_e;
  logic [63:0]   got_seq = 64'd0;
  int            got_n = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc;
  int            wid = 1;

  arbitro_salida dut (
    .clk(clk), .reset(reset), .state(state),
    .empty0(empty0), .empty1(empty1), .empty2(empty2), .empty3(empty3),
    .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
    .almost_full_out(almost_full_out),
    .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
    .push_out(push_out), .data_out(data_out), .grant(grant), .idle(idle)
  );

  always #5 clk = ~clk;

  assign empty0 = (pushed[0] == popped[0]);
  assign empty1 = (pushed[1] == popped[1]);
  assign empty2 = (pushed[2] == popped[2]);
  assign empty3 = (pushed[3] == popped[3]);

  // Channel FIFO model: read data appears the cycle after the pop
  always @(posedge clk) begin
    logic [3:0] p;
    p = {pop3, pop2, pop1, pop0};
    for (int k = 0; k < 4; k++) begin
      if (p[k] === 1'b1) begin
        din[k]    <= mem[k][popped[k] % 256];
        popped[k] <= popped[k] + 1;
      end
    end
  end

  // Scoreboard: queue the popped word, then check the push after the edge
  always @(posedge clk) begin
    logic [3:0] p;
    p = {pop3, pop2, pop1, pop0};
    n_checks++;
    if ($countones(p) > 1) begin
      n_fail++;
      $display("FAIL pop_onehot: pops=%b, at most one expected", p);
    end
    for (int k = 0; k < 4; k++) begin
      if (p[k] === 1'b1) exp_q.push_back({2'(k), mem[k][popped[k] % 256]});
    end
    #1;
    if (push_out === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL push_unexpected: grant=%0d data=%h, no push expected", grant, data_out);
      end else begin
        exp_e = exp_q.pop_front();
        if ({grant, data_out} !== exp_e) begin
          n_fail++;
          $display("FAIL push_data: got grant=%0d data=%h, want grant=%0d data=%h",
                   grant, data_out, exp_e[7:6], exp_e[5:0]);
        end
        got_seq = {got_seq[61:0], grant};
        got_n++;
      end
    end else if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_missing: push_out=%b, want 1 for queued word", push_out);
      exp_q.delete();
    end
  end

  task automatic load(input int k, input logic [DW-1:0] w);
    mem[k][pushed[k] % 256] = w;
    pushed[k] = pushed[k] + 1;
  endtask

  task automatic load_n(input int k, input int n);
    for (int j = 0; j < n; j++) begin
      load(k, 6'(wid));
      wid = (wid % 63) + 1;
    end
  endtask

  task automatic hold_reset();
    @(negedge clk);
    reset = 1'b1;
    state = 4'b0010;
    almost_full_out = 1'b0;
    repeat (2) @(negedge clk);
    got_seq = 64'd0;
    got_n = 0;
  endtask

  task automatic wait_words(input int n, input int budget, output int cycles);
    cycles = 0;
    while (got_n < n && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    for (int pass = 0; pass < 2; pass++) begin
      hold_reset();
      if (pass == 1) begin
        reset = 1'b0;
        state = 4'b0001;
      end
      for (int k = 0; k < 4; k++) load(k, 6'(k + 1));
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if ({pop3, pop2, pop1, pop0} !== 4'b0000) begin
        n_fail++; $display("FAIL flush%0d_pop: got %b want 0000", pass, {pop3, pop2, pop1, pop0});
      end
      n_checks++;
      if (push_out !== 1'b0) begin n_fail++; $display("FAIL flush%0d_push: got %b want 0", pass, push_out); end
      n_checks++;
      if (data_out !== 6'd0) begin n_fail++; $display("FAIL flush%0d_data: got %h want 00", pass, data_out); end
      n_checks++;
      if (grant !== 2'd0) begin n_fail++; $display("FAIL flush%0d_grant: got %0d want 0", pass, grant); end
      n_checks++;
      if (idle !== 1'b0) begin n_fail++; $display("FAIL flush%0d_idle: got %b want 0", pass, idle); end
      reset = 1'b0;
      state = 4'b0010;
      wait_words(4, 20, cyc);
      n_checks++;
      if (got_n !== 4 || got_seq[7:0] !== 8'h1B) begin
        n_fail++; $display("FAIL flush%0d_drain: got n=%0d seq=%h want n=4 seq=1b", pass, got_n, got_seq[7:0]);
      end
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (idle !== 1'b1) begin n_fail++; $display("FAIL flush%0d_idle_end: got %b want 1", pass, idle); end
    end
  endtask

  task automatic test_flush_mid();
    hold_reset();
    load(0, 6'h31); load(1, 6'h32); load(2, 6'h33); load(2, 6'h34); load(3, 6'h35);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    state = 4'b0001;
    #1;
    n_checks++;
    if ({pop3, pop2, pop1, pop0} !== 4'b0000 || got_n !== 3) begin
      n_fail++; $display("FAIL mid_flush_pop: got pops=%b n=%0d want 0000 n=3", {pop3, pop2, pop1, pop0}, got_n);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({push_out, grant, data_out} !== 9'd0) begin
      n_fail++; $display("FAIL mid_flush_regs: got push=%b grant=%0d data=%h want all 0", push_out, grant, data_out);
    end
    state = 4'b0010;
    wait_words(5, 20, cyc);
    n_checks++;
    if (got_n !== 5 || got_seq[9:0] !== 10'h06B) begin
      n_fail++; $display("FAIL mid_flush_resume: got n=%0d seq=%h want n=5 seq=06b", got_n, got_seq[9:0]);
    end
  endtask

`ifndef ARBITRO_SALIDA_WRR_EN
  task automatic test_round_robin();
    hold_reset();
    for (int k = 0; k < 4; k++) load(k, 6'(8'h10 + k));
    for (int k = 0; k < 4; k++) load(k, 6'(8'h20 + k));
    @(negedge clk);
    reset = 1'b0;
    wait_words(8, 30, cyc);
    n_checks++;
    if (got_n !== 8 || got_seq[15:0] !== 16'h1B1B) begin
      n_fail++; $display("FAIL rr_seq: got n=%0d seq=%h want n=8 seq=1b1b", got_n, got_seq[15:0]);
    end
    n_checks++;
    if (cyc !== 8) begin n_fail++; $display("FAIL rr_rate: got %0d cycles want 8", cyc); end
  endtask

  task automatic test_skip_empty();
    hold_reset();
    load_n(1, 2);
    load_n(3, 2);
    @(negedge clk);
    reset = 1'b0;
    wait_words(4, 20, cyc);
    n_checks++;
    if (got_n !== 4 || got_seq[7:0] !== 8'h77) begin
      n_fail++; $display("FAIL skip_seq: got n=%0d seq=%h want n=4 seq=77", got_n, got_seq[7:0]);
    end
    n_checks++;
    if (cyc !== 4) begin n_fail++; $display("FAIL skip_rate: got %0d cycles want 4", cyc); end
  endtask

  task automatic test_back_pressure();
    hold_reset();
    for (int k = 0; k < 4; k++) load_n(k, 3);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    almost_full_out = 1'b1;
    #1;
    n_checks++;
    if ({pop3, pop2, pop1, pop0} !== 4'b0000) begin
      n_fail++; $display("FAIL bp_stall: got pops=%b want 0000", {pop3, pop2, pop1, pop0});
    end
    n_checks++;
    if (push_out !== 1'b1 || grant !== 2'd1) begin
      n_fail++; $display("FAIL bp_trailing: got push=%b grant=%0d want push=1 grant=1", push_out, grant);
    end
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (got_n !== 2 || push_out !== 1'b0 || idle !== 1'b0) begin
      n_fail++; $display("FAIL bp_hold: got n=%0d push=%b idle=%b want n=2 push=0 idle=0", got_n, push_out, idle);
    end
    almost_full_out = 1'b0;
    wait_words(12, 30, cyc);
    n_checks++;
    if (got_n !== 12 || got_seq[23:0] !== 24'h1B1B1B) begin
      n_fail++; $display("FAIL bp_resume: got n=%0d seq=%h want n=12 seq=1b1b1b", got_n, got_seq[23:0]);
    end
  endtask
`else
  task automatic test_wrr();
    hold_reset();
    load_n(0, 8); load_n(1, 4); load_n(2, 2); load_n(3, 2);
    @(negedge clk);
    reset = 1'b0;
    wait_words(16, 40, cyc);
    n_checks++;
    if (got_n !== 16 || got_seq[31:0] !== 32'h005B005B) begin
      n_fail++; $display("FAIL wrr_deep: got n=%0d seq=%h want n=16 seq=005b005b", got_n, got_seq[31:0]);
    end
    n_checks++;
    if (cyc !== 16) begin n_fail++; $display("FAIL wrr_rate: got %0d cycles want 16", cyc); end
    hold_reset();
    load_n(0, 2); load_n(1, 2); load_n(2, 1); load_n(3, 1);
    @(negedge clk);
    reset = 1'b0;
    wait_words(6, 20, cyc);
    n_checks++;
    if (got_n !== 6 || got_seq[11:0] !== 12'h05B) begin
      n_fail++; $display("FAIL wrr_short: got n=%0d seq=%h want n=6 seq=05b", got_n, got_seq[11:0]);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifndef ARBITRO_SALIDA_WRR_EN
    test_round_robin();
    test_skip_empty();
    test_back_pressure();
`else
    test_wrr();
`endif
    test_flush_mid();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
